// File: rtl/game_sprite_pkg.sv
// Shared definitions for the game sprite: lifecycle state encoding and
// the layout of one bitmap pixel (opaque flag above the colour field).
package game_sprite_pkg;

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DYING  = 2'd2
  } sprite_state_e;

  localparam int PIX_COLOUR_LSB = 0;

  // The opaque flag sits directly above the colour bits.
  function automatic int pix_opaque_bit(input int rgb_width);
    return rgb_width;
  endfunction

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_sprite_if.sv
// Bundle between game logic / VGA mux (master) and one sprite (slave).
interface game_sprite_if #(
  parameter int X_WIDTH   = 11,
  parameter int Y_WIDTH   = 11,
  parameter int DX_WIDTH  = 3,
  parameter int DY_WIDTH  = 3,
  parameter int RGB_WIDTH = 3,
  parameter int FRAME_W   = 2
);
  // Commands (sprite_write, sprite_kill, frame_tick) are single-cycle pulses with
  // no back-pressure: the sprite always accepts them on the edge they are high.
  logic                        frame_tick;
  logic        [X_WIDTH-1:0]   pixel_x;
  logic        [Y_WIDTH-1:0]   pixel_y;
  logic                        sprite_write;
  logic signed [X_WIDTH-1:0]   sprite_write_x;
  logic signed [Y_WIDTH-1:0]   sprite_write_y;
  logic signed [DX_WIDTH-1:0]  sprite_write_dx;
  logic signed [DY_WIDTH-1:0]  sprite_write_dy;
  logic                        sprite_kill;
  logic signed [X_WIDTH-1:0]   sprite_x;
  logic signed [Y_WIDTH-1:0]   sprite_y;
  logic signed [DX_WIDTH-1:0]  sprite_dx;
  logic signed [DY_WIDTH-1:0]  sprite_dy;
  logic        [1:0]           sprite_state;
  logic        [FRAME_W-1:0]   anim_frame;
  logic                        sprite_within_screen;
  logic                        sprite_out_left;
  logic                        sprite_out_right;
  logic                        sprite_out_top;
  logic                        sprite_out_bottom;
  logic                        rgb_en;
  logic        [RGB_WIDTH-1:0] rgb;

  modport master (
    output frame_tick, pixel_x, pixel_y, sprite_write, sprite_write_x,
           sprite_write_y, sprite_write_dx, sprite_write_dy, sprite_kill,
    input  sprite_x, sprite_y, sprite_dx, sprite_dy, sprite_state, anim_frame,
           sprite_within_screen, sprite_out_left, sprite_out_right,
           sprite_out_top, sprite_out_bottom, rgb_en, rgb
  );

  modport slave (
    input  frame_tick, pixel_x, pixel_y, sprite_write, sprite_write_x,
           sprite_write_y, sprite_write_dx, sprite_write_dy, sprite_kill,
    output sprite_x, sprite_y, sprite_dx, sprite_dy, sprite_state, anim_frame,
           sprite_within_screen, sprite_out_left, sprite_out_right,
           sprite_out_top, sprite_out_bottom, rgb_en, rgb
  );
endinterface

// File: rtl/game_sprite_axis.sv
// One motion axis: position and speed registers with a wrapping or
// edge-reflecting step per frame tick.
module game_sprite_axis #(
  parameter int P_WIDTH = 11,
  parameter int S_WIDTH = 3,
  parameter int SCREEN  = 640,
  parameter int SPRITE  = 8,
  parameter int BOUNCE  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load,
  input  logic signed [P_WIDTH-1:0] i_load_pos,
  input  logic signed [S_WIDTH-1:0] i_load_spd,
  input  logic                      i_step,
  output logic signed [P_WIDTH-1:0] o_pos,
  output logic signed [S_WIDTH-1:0] o_spd
);
  localparam int NW = P_WIDTH + 1;
  localparam logic signed [S_WIDTH-1:0] SPD_MIN = {1'b1, {(S_WIDTH-1){1'b0}}};
  localparam logic signed [S_WIDTH-1:0] SPD_MAX = {1'b0, {(S_WIDTH-1){1'b1}}};

  logic signed [P_WIDTH-1:0] r_pos;
  logic signed [S_WIDTH-1:0] r_spd;
  logic signed [NW-1:0]      w_nxt;
  int                        w_nxt_int;
  logic                      w_edge;
  logic signed [S_WIDTH-1:0] w_neg;

  // One extra bit so the edge test sees the true sum before wrap.
  assign w_nxt     = NW'(r_pos) + NW'(r_spd);
  assign w_nxt_int = int'(w_nxt);
  assign w_edge    = (w_nxt_int < 0) || (w_nxt_int + SPRITE > SCREEN);
  assign w_neg     = (r_spd == SPD_MIN) ? SPD_MAX : -r_spd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pos <= '0;
      r_spd <= '0;
    end else if (i_load) begin
      r_pos <= i_load_pos;
      r_spd <= i_load_spd;
    end else if (i_step) begin
      if ((BOUNCE != 0) && w_edge) r_spd <= w_neg;
      else                         r_pos <= w_nxt[P_WIDTH-1:0];
    end
  end

  assign o_pos = r_pos;
  assign o_spd = r_spd;
endmodule

// File: rtl/game_sprite_anim_top.sv
// Animated game sprite: lifecycle FSM, animation sequencer, two motion axes,
// screen-edge flags and a registered pixel overlay for the VGA mux.
module game_sprite_anim_top
  import game_sprite_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int X_WIDTH       = 11,
  parameter int Y_WIDTH       = 11,
  parameter int DX_WIDTH      = 3,
  parameter int DY_WIDTH      = 3,
  parameter int RGB_WIDTH     = 3,
  parameter int FRAMES        = 4,
  parameter int FRAME_TICKS   = 8,
  parameter int DIE_TICKS     = 16,
  parameter int BOUNCE        = 0,
  parameter logic [FRAMES*SPRITE_HEIGHT*SPRITE_WIDTH*(RGB_WIDTH+1)-1:0] BITMAP = '0
) (
  input logic          clk,
  input logic          reset,
  game_sprite_if.slave bus
);
  localparam int BITMAP_BITS = FRAMES * SPRITE_HEIGHT * SPRITE_WIDTH * (RGB_WIDTH + 1);
  localparam int BW  = min1_clog2(BITMAP_BITS);
  localparam int FW  = min1_clog2(FRAMES);
  localparam int AW  = min1_clog2(FRAME_TICKS);
  localparam int DW  = (DIE_TICKS > 4) ? $clog2(DIE_TICKS) : 2;
  localparam int CW  = min1_clog2(SPRITE_WIDTH);
  localparam int RW  = min1_clog2(SPRITE_HEIGHT);
  localparam int PW  = RGB_WIDTH + 1;
  localparam int OPQ = pix_opaque_bit(RGB_WIDTH);
  localparam int XN  = X_WIDTH + 1;
  localparam int YN  = Y_WIDTH + 1;
  localparam logic [AW-1:0] ANIM_LAST  = AW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [DW-1:0] DIE_LAST   = DW'(DIE_TICKS - 1);

  sprite_state_e             r_state, w_state_nxt;
  logic [AW-1:0]             r_anim_cnt;
  logic [FW-1:0]             r_frame;
  logic [DW-1:0]             r_die_cnt;
  logic                      w_kill, w_step, w_die_tick;
  logic signed [X_WIDTH-1:0] w_x;
  logic signed [Y_WIDTH-1:0] w_y;
  int                        w_x_int, w_y_int;
  logic signed [XN-1:0]      w_dc;
  logic signed [YN-1:0]      w_dr;
  logic                      w_hit, w_visible, w_en;
  logic [BW-1:0]             w_base;
  logic [PW-1:0]             w_pix;
  logic                      r_rgb_en;
  logic [RGB_WIDTH-1:0]      r_rgb;

  // Write beats kill beats tick; kill only lands while ACTIVE.
  assign w_kill     = bus.sprite_kill && !bus.sprite_write && (r_state == ST_ACTIVE);
  assign w_step     = bus.frame_tick && !bus.sprite_write && !bus.sprite_kill && (r_state == ST_ACTIVE);
  assign w_die_tick = bus.frame_tick && !bus.sprite_write && (r_state == ST_DYING);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_HIDDEN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.sprite_write)                           w_state_nxt = ST_ACTIVE;
    else if (w_kill)                                w_state_nxt = ST_DYING;
    else if (w_die_tick && (r_die_cnt == DIE_LAST)) w_state_nxt = ST_HIDDEN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_anim_cnt <= '0;
      r_frame    <= '0;
      r_die_cnt  <= '0;
    end else begin
      if (bus.sprite_write) begin
        r_anim_cnt <= '0;
        r_frame    <= '0;
      end else if (w_step) begin
        if (r_anim_cnt == ANIM_LAST) begin
          r_anim_cnt <= '0;
          r_frame    <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
        end else begin
          r_anim_cnt <= r_anim_cnt + 1'b1;
        end
      end
      if (w_kill)          r_die_cnt <= '0;
      else if (w_die_tick) r_die_cnt <= r_die_cnt + 1'b1;
    end
  end

  game_sprite_axis #(
    .P_WIDTH(X_WIDTH), .S_WIDTH(DX_WIDTH), .SCREEN(SCREEN_WIDTH),
    .SPRITE(SPRITE_WIDTH), .BOUNCE(BOUNCE)
  ) u_axis_x (
    .clk(clk), .reset(reset), .i_load(bus.sprite_write),
    .i_load_pos(bus.sprite_write_x), .i_load_spd(bus.sprite_write_dx),
    .i_step(w_step), .o_pos(w_x), .o_spd(bus.sprite_dx)
  );

  game_sprite_axis #(
    .P_WIDTH(Y_WIDTH), .S_WIDTH(DY_WIDTH), .SCREEN(SCREEN_HEIGHT),
    .SPRITE(SPRITE_HEIGHT), .BOUNCE(BOUNCE)
  ) u_axis_y (
    .clk(clk), .reset(reset), .i_load(bus.sprite_write),
    .i_load_pos(bus.sprite_write_y), .i_load_spd(bus.sprite_write_dy),
    .i_step(w_step), .o_pos(w_y), .o_spd(bus.sprite_dy)
  );

  assign w_x_int = int'(w_x);
  assign w_y_int = int'(w_y);
  assign bus.sprite_out_left      = (w_x_int < 0);
  assign bus.sprite_out_right     = (w_x_int + SPRITE_WIDTH > SCREEN_WIDTH);
  assign bus.sprite_out_top       = (w_y_int < 0);
  assign bus.sprite_out_bottom    = (w_y_int + SPRITE_HEIGHT > SCREEN_HEIGHT);
  assign bus.sprite_within_screen = !(bus.sprite_out_left || bus.sprite_out_right ||
                                      bus.sprite_out_top  || bus.sprite_out_bottom);

  // Beam offset inside the sprite box; negative or too large means a miss.
  assign w_dc  = $signed({1'b0, bus.pixel_x}) - XN'(w_x);
  assign w_dr  = $signed({1'b0, bus.pixel_y}) - YN'(w_y);
  assign w_hit = !w_dc[XN-1] && (int'(w_dc) < SPRITE_WIDTH) &&
                 !w_dr[YN-1] && (int'(w_dr) < SPRITE_HEIGHT);

  assign w_base = BW'(((int'(r_frame) * SPRITE_HEIGHT + int'(w_dr[RW-1:0])) * SPRITE_WIDTH
                       + int'(w_dc[CW-1:0])) * PW);
  assign w_pix  = BITMAP[w_base +: PW];

  // Dying sprites blink on bit 1 of the die counter.
  assign w_visible = (r_state == ST_ACTIVE) || ((r_state == ST_DYING) && !r_die_cnt[1]);
  assign w_en      = w_hit && w_pix[OPQ] && w_visible;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rgb_en <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_rgb_en <= w_en;
      r_rgb    <= w_en ? w_pix[PIX_COLOUR_LSB +: RGB_WIDTH] : '0;
    end
  end

  assign bus.sprite_x     = w_x;
  assign bus.sprite_y     = w_y;
  assign bus.sprite_state = r_state;
  assign bus.anim_frame   = r_frame;
  assign bus.rgb_en       = r_rgb_en;
  assign bus.rgb          = r_rgb;
endmodule

// File: tb/tb_game_sprite_anim_top.sv
// Directed bench for game_sprite_anim_top: a wrapping instance and a bouncing
// instance (FRAME_TICKS=2, DIE_TICKS=4) share clock, reset and frame_tick.
module tb_game_sprite_anim_top;

  localparam int BMW = 4 * 8 * 8 * 4;

  // Test bitmap: diagonal (r==c) transparent, colour = (2*frame + col) mod 8.
  function automatic logic [BMW-1:0] make_bitmap();
    logic [BMW-1:0] b;
    b = '0;
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          b[((f * 8 + r) * 8 + c) * 4 +: 4] = {(r != c), 3'((f * 2 + c) % 8)};
    return b;
  endfunction

  localparam logic [BMW-1:0] BMP = make_bitmap();

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];

  game_sprite_if bw();
  game_sprite_if bb();

  game_sprite_anim_top #(.BOUNCE(0), .BITMAP(BMP)) u_wrap (
    .clk(clk), .reset(reset), .bus(bw)
  );

  game_sprite_anim_top #(.BOUNCE(1), .FRAME_TICKS(2), .DIE_TICKS(4), .BITMAP(BMP)) u_bnc (
    .clk(clk), .reset(reset), .bus(bb)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_all();
    bw.frame_tick = 1'b0; bw.sprite_write = 1'b0; bw.sprite_kill = 1'b0;
    bw.pixel_x = '0; bw.pixel_y = '0;
    bw.sprite_write_x = '0; bw.sprite_write_y = '0;
    bw.sprite_write_dx = '0; bw.sprite_write_dy = '0;
    bb.frame_tick = 1'b0; bb.sprite_write = 1'b0; bb.sprite_kill = 1'b0;
    bb.pixel_x = '0; bb.pixel_y = '0;
    bb.sprite_write_x = '0; bb.sprite_write_y = '0;
    bb.sprite_write_dx = '0; bb.sprite_write_dy = '0;
  endtask

  task automatic wr(input bit sel, input int x, input int y, input int dx, input int dy);
    @(negedge clk);
    if (sel) begin
      bb.sprite_write = 1'b1;
      bb.sprite_write_x = 11'(x); bb.sprite_write_y = 11'(y);
      bb.sprite_write_dx = 3'(dx); bb.sprite_write_dy = 3'(dy);
    end else begin
      bw.sprite_write = 1'b1;
      bw.sprite_write_x = 11'(x); bw.sprite_write_y = 11'(y);
      bw.sprite_write_dx = 3'(dx); bw.sprite_write_dy = 3'(dy);
    end
    @(negedge clk);
    bw.sprite_write = 1'b0;
    bb.sprite_write = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      bw.frame_tick = 1'b1; bb.frame_tick = 1'b1;
      @(negedge clk);
      bw.frame_tick = 1'b0; bb.frame_tick = 1'b0;
    end
  endtask

  task automatic kill_b();
    @(negedge clk);
    bb.sprite_kill = 1'b1;
    @(negedge clk);
    bb.sprite_kill = 1'b0;
  endtask

  task automatic pix(input bit sel, input int px, input int py);
    @(negedge clk);
    if (sel) begin bb.pixel_x = 11'(px); bb.pixel_y = 11'(py); end
    else     begin bw.pixel_x = 11'(px); bw.pixel_y = 11'(py); end
    @(negedge clk);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    repeat (3) @(negedge clk);
    check("rst_state_w", bw.sprite_state, 0);
    check("rst_x_w", bw.sprite_x, 0);
    check("rst_out_right_w", bw.sprite_out_right, 0);
    check("rst_state_b", bb.sprite_state, 0);
    check("rst_rgb_en_b", bb.rgb_en, 0);
    check("rst_frame_b", bb.anim_frame, 0);
    reset = 1'b1;

    // reset in the middle of ACTIVE
    wr(0, 100, 50, 1, 0);
    check("act_state", bw.sprite_state, 1);
    tick_n(1);
    check("act_x", bw.sprite_x, 101);
    pix(0, 104, 52);
    check("act_rgb_en", bw.rgb_en, 1);
    check("act_rgb", bw.rgb, 3);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("mid_rst_state", bw.sprite_state, 0);
    check("mid_rst_x", bw.sprite_x, 0);
    check("mid_rst_rgb_en", bw.rgb_en, 0);
    reset = 1'b1;
    tick_n(2);
    check("hidden_tick_state", bw.sprite_state, 0);
    check("hidden_tick_x", bw.sprite_x, 0);

    // wrapping motion and edge flags
    wr(0, 638, 10, 1, 0);
    tick_n(3);
    check("wrap_x641", bw.sprite_x, 641);
    check("wrap_out_right", bw.sprite_out_right, 1);
    check("wrap_within", bw.sprite_within_screen, 0);
    wr(0, 1023, 10, 1, 0);
    tick_n(1);
    check("wrap_x_min", bw.sprite_x, -1024);
    check("wrap_out_left", bw.sprite_out_left, 1);
    wr(0, 100, 0, 0, -1);
    tick_n(1);
    check("wrap_y_neg", bw.sprite_y, -1);
    check("wrap_out_top", bw.sprite_out_top, 1);
    wr(0, 632, 472, 0, 0);
    check("edge_right_632", bw.sprite_out_right, 0);
    check("edge_bottom_472", bw.sprite_out_bottom, 0);
    check("edge_within", bw.sprite_within_screen, 1);
    wr(0, 633, 473, 0, 0);
    check("edge_right_633", bw.sprite_out_right, 1);
    check("edge_bottom_473", bw.sprite_out_bottom, 1);

    // bouncing motion
    wr(1, 633, 100, 3, 0);
    tick_n(1);
    check("bnc_x_hold", bb.sprite_x, 633);
    check("bnc_dx_neg", bb.sprite_dx, -3);
    tick_n(1);
    check("bnc_x630", bb.sprite_x, 630);
    wr(1, 1, 100, -4, 0);
    tick_n(1);
    check("bnc_sat_x", bb.sprite_x, 1);
    check("bnc_sat_dx", bb.sprite_dx, 3);
    wr(1, 10, 470, 0, 2);
    tick_n(1);
    check("bnc_y472", bb.sprite_y, 472);
    check("bnc_dy_keep", bb.sprite_dy, 2);
    tick_n(1);
    check("bnc_y_hold", bb.sprite_y, 472);
    check("bnc_dy_neg", bb.sprite_dy, -2);

    // animation and pixel lookup
    wr(1, 100, 100, 0, 0);
    check("anim_start", bb.anim_frame, 0);
    pix(1, 103, 102);
    check("pix_f0_en", bb.rgb_en, 1);
    check("pix_f0_rgb", bb.rgb, 3);
    pix(1, 104, 104);
    check("pix_diag_en", bb.rgb_en, 0);
    check("pix_diag_rgb", bb.rgb, 0);
    pix(1, 108, 102);
    check("pix_right_miss", bb.rgb_en, 0);
    pix(1, 99, 102);
    check("pix_left_miss", bb.rgb_en, 0);
    pix(1, 103, 99);
    check("pix_above_miss", bb.rgb_en, 0);
    exp_q = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 8; i++) begin
      logic [1:0] e;
      tick_n(1);
      e = exp_q.pop_front();
      check("anim_frame", bb.anim_frame, e);
      if (i == 1) begin
        pix(1, 103, 102);
        check("pix_f1_rgb", bb.rgb, 5);
      end
      if (i == 5) begin
        pix(1, 103, 102);
        check("pix_f3_rgb", bb.rgb, 1);
      end
    end

    // kill, blink and return to HIDDEN
    wr(1, 200, 100, 1, 0);
    tick_n(2);
    check("pre_kill_x", bb.sprite_x, 202);
    check("pre_kill_frame", bb.anim_frame, 1);
    pix(1, 205, 102);
    check("pre_kill_rgb", bb.rgb, 5);
    kill_b();
    check("kill_state", bb.sprite_state, 2);
    cyc();
    check("die0_en", bb.rgb_en, 1);
    tick_n(1); cyc();
    check("die1_en", bb.rgb_en, 1);
    check("die_x_frozen", bb.sprite_x, 202);
    check("die_frame_frozen", bb.anim_frame, 1);
    tick_n(1); cyc();
    check("die2_en", bb.rgb_en, 0);
    tick_n(1); cyc();
    check("die3_en", bb.rgb_en, 0);
    check("die3_state", bb.sprite_state, 2);
    tick_n(1);
    check("die_end_state", bb.sprite_state, 0);
    cyc();
    check("hidden_en", bb.rgb_en, 0);
    kill_b();
    check("kill_in_hidden", bb.sprite_state, 0);

    // write and kill on the same clock
    wr(1, 300, 100, 0, 0);
    @(negedge clk);
    bb.sprite_kill = 1'b1; bb.sprite_write = 1'b1; bb.sprite_write_x = 11'(310);
    @(negedge clk);
    bb.sprite_kill = 1'b0; bb.sprite_write = 1'b0;
    check("wr_kill_state", bb.sprite_state, 1);
    check("wr_kill_x", bb.sprite_x, 310);

    // partially off the left edge
    wr(1, -3, 100, 0, 0);
    check("left_x", bb.sprite_x, -3);
    check("left_out_left", bb.sprite_out_left, 1);
    check("left_within", bb.sprite_within_screen, 0);
    pix(1, 0, 102);
    check("left_px0_en", bb.rgb_en, 1);
    check("left_px0_rgb", bb.rgb, 3);
    pix(1, 4, 102);
    check("left_px4_rgb", bb.rgb, 7);
    pix(1, 5, 102);
    check("left_px5_en", bb.rgb_en, 0);
    pix(1, 0, 103);
    check("left_diag_en", bb.rgb_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
